pe_array_v2: RTL

Parametrised successor processing-element array. It instantiates NUM_PE `pe` lanes and fans one upstream transaction out to them with a correct per-lane input join, so that no lane is ever double-fed or skipped. Results are collected into per-lane output FIFOs and released downstream as a single aligned transaction. Adds activation-broadcast mode, per-transaction lane masking and credit-based flow control. Sits between the operand scheduler and the result writeback in the dequant-GEMV datapath.

---
 rtl/earth_pkg.sv | 34 +++
 rtl/pe_array_v2_if.sv | 33 +++
 rtl/lane_fifo.sv | 49 ++++
 rtl/pe.sv | 81 ++++++++
 rtl/pe_array_v2.sv | 128 ++++++++++++
 5 files changed

// File: rtl/earth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : earth_pkg
// Description : Shared widths and helpers for the dequant-GEMV datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package earth_pkg;

    localparam int FP16_W      = 16;
    localparam int INT4_W      = 4;
    localparam int ACTS_PER_PE = 4;
    localparam int PE_W_BITS   = 256;
    localparam int PE_OUT_BITS = 256;

    localparam int PE_ACT_BITS = ACTS_PER_PE * FP16_W;
    localparam int PE_ROWS     = PE_OUT_BITS / FP16_W;
    localparam int PE_WEIGHTS  = PE_W_BITS / INT4_W;

    typedef enum logic [1:0] {
        PE_IDLE = 2'd0,
        PE_BUSY = 2'd1,
        PE_DONE = 2'd2
    } pe_state_e;

    // One MAC term: activation scaled by a sign-extended int4 weight, kept to 16 bits.
    function automatic logic [FP16_W-1:0] int4_scale(input logic [FP16_W-1:0] act,
                                                     input logic [INT4_W-1:0] wt);
        logic [FP16_W-1:0] wt_ext;
        wt_ext = {{(FP16_W-INT4_W){wt[INT4_W-1]}}, wt};
        return act * wt_ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_array_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_v2_if
// Description : Upstream/downstream transaction bundle of the PE array.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_array_v2_if #(
    parameter int NUM_PE     = 16,
    parameter int FIFO_DEPTH = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_bcast;
    logic [NUM_PE-1:0]               in_lane_en;
    logic [NUM_PE*64-1:0]            in_fp16_acts;
    logic [NUM_PE*256-1:0]           in_int4s;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_PE-1:0]               out_lane_en;
    logic [NUM_PE*256-1:0]           out_fp16s;
    logic [$clog2(FIFO_DEPTH):0]     inflight;

    modport master (
        output in_valid, in_bcast, in_lane_en, in_fp16_acts, in_int4s, out_ready,
        input  in_ready, out_valid, out_lane_en, out_fp16s, inflight
    );

    modport slave (
        input  in_valid, in_bcast, in_lane_en, in_fp16_acts, in_int4s, out_ready,
        output in_ready, out_valid, out_lane_en, out_fp16s, inflight
    );
endinterface
`default_nettype wire

// File: rtl/lane_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lane_fifo
// Description : Synchronous FIFO with storage-register read port.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 256
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              push,
    input  wire  [WIDTH-1:0] push_data,
    input  wire              pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !w_full) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop && !empty)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !w_full) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

    // Upstream credits make overflow impossible; a full push means broken flow control.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && w_full));

endmodule
`default_nettype wire

// File: rtl/pe.sv
`default_nettype none
// ============================================================================
// Module      : pe
// Description : Processing element; four-step MAC of 16 int4 weight rows
//               against a 4-element activation vector.
// Revision    : 1.0 - initial release
// ============================================================================
module pe
    import earth_pkg::*;
(
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    in_valid,
    output logic                   in_ready,
    input  wire  [PE_ACT_BITS-1:0] in_fp16_acts,
    input  wire  [PE_W_BITS-1:0]   in_int4s,
    output logic                   out_valid,
    input  wire                    out_ready,
    output logic [PE_OUT_BITS-1:0] out_fp16s
);
    localparam int K_W = $clog2(ACTS_PER_PE);
    localparam logic [K_W-1:0] K_LAST = K_W'(ACTS_PER_PE - 1);

    pe_state_e                             r_state;
    pe_state_e                             w_state_nxt;
    logic [ACTS_PER_PE-1:0][FP16_W-1:0]    r_acts;
    logic [PE_WEIGHTS-1:0][INT4_W-1:0]     r_wts;
    logic [PE_ROWS-1:0][FP16_W-1:0]        r_acc;
    logic [K_W-1:0]                        r_k;
    logic                                  w_accept;

    assign w_accept  = in_valid && in_ready;
    assign out_fp16s = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= PE_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            PE_IDLE: in_ready = 1'b1;
            PE_BUSY: if (r_k == K_LAST) w_state_nxt = PE_DONE;
            PE_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_state_nxt = PE_IDLE;
            end
            default: w_state_nxt = PE_IDLE;
        endcase
        if (in_valid && in_ready) w_state_nxt = PE_BUSY;
    end

    // Term 0 is folded into the accept cycle so the unit is busy ACTS_PER_PE-1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acts <= '0;
            r_wts  <= '0;
            r_acc  <= '0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_acts <= in_fp16_acts;
            r_wts  <= in_int4s;
            r_k    <= K_W'(1);
            for (int r = 0; r < PE_ROWS; r++) begin
                r_acc[r] <= int4_scale(in_fp16_acts[FP16_W-1:0],
                                       in_int4s[r*ACTS_PER_PE*INT4_W +: INT4_W]);
            end
        end else if (r_state == PE_BUSY) begin
            r_k <= r_k + 1'b1;
            for (int r = 0; r < PE_ROWS; r++) begin
                r_acc[r] <= r_acc[r] + int4_scale(r_acts[r_k], r_wts[r*ACTS_PER_PE + int'(r_k)]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_array_v2.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_v2
// Description : NUM_PE pe lanes with joined input fan-out, per-lane result
//               FIFOs, mask-ordered aligned output and credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_array_v2
    import earth_pkg::*;
#(
    parameter int NUM_PE     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire           clk,
    input  wire           rst_n,
    pe_array_v2_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PE-1:0]                  r_done;
    logic [CNT_W-1:0]                   r_inflight;
    logic [NUM_PE-1:0]                  w_pe_in_valid;
    logic [NUM_PE-1:0]                  w_pe_in_ready;
    logic [NUM_PE-1:0]                  w_pe_out_valid;
    logic [NUM_PE-1:0][PE_OUT_BITS-1:0] w_pe_out;
    logic [NUM_PE-1:0][PE_OUT_BITS-1:0] w_lane_data;
    logic [NUM_PE-1:0]                  w_lane_empty;
    logic [NUM_PE-1:0]                  w_lane_pop;
    logic [NUM_PE-1:0]                  w_lane_ok;
    logic [NUM_PE-1:0]                  w_present;
    logic [NUM_PE-1:0]                  w_mask_head;
    logic [NUM_PE-1:0]                  w_out_en;
    logic [NUM_PE*PE_OUT_BITS-1:0]      w_out_data;
    logic                               w_mask_empty;
    logic                               w_credit_ok;
    logic                               w_up_hs;
    logic                               w_dn_hs;
    logic                               w_out_valid;

    // Gating with rst_n keeps in_ready low and the pes unfed while reset is held.
    assign w_credit_ok   = rst_n && (r_inflight < CNT_W'(FIFO_DEPTH));
    assign w_pe_in_valid = {NUM_PE{bus.in_valid && w_credit_ok}} & bus.in_lane_en & ~r_done;
    assign w_lane_ok     = ~bus.in_lane_en | r_done | w_pe_in_ready;
    assign bus.in_ready  = w_credit_ok && (&w_lane_ok);
    assign w_up_hs       = bus.in_valid && bus.in_ready;

    assign w_present     = ~w_mask_head | ~w_lane_empty;
    assign w_out_valid   = !w_mask_empty && (&w_present);
    assign w_dn_hs       = w_out_valid && bus.out_ready;
    assign w_lane_pop    = {NUM_PE{w_dn_hs}} & w_mask_head;
    assign w_out_en      = w_mask_empty ? '0 : w_mask_head;

    assign bus.out_valid   = w_out_valid;
    assign bus.out_lane_en = w_out_en;
    assign bus.out_fp16s   = w_out_data;
    assign bus.inflight    = r_inflight;

    generate
        for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
            logic [PE_ACT_BITS-1:0] w_acts;

            assign w_acts = bus.in_bcast ? bus.in_fp16_acts[PE_ACT_BITS-1:0]
                                         : bus.in_fp16_acts[i*PE_ACT_BITS +: PE_ACT_BITS];

            pe u_pe (
                .clk          (clk),
                .rst_n        (rst_n),
                .in_valid     (w_pe_in_valid[i]),
                .in_ready     (w_pe_in_ready[i]),
                .in_fp16_acts (w_acts),
                .in_int4s     (bus.in_int4s[i*PE_W_BITS +: PE_W_BITS]),
                .out_valid    (w_pe_out_valid[i]),
                .out_ready    (1'b1),
                .out_fp16s    (w_pe_out[i])
            );

            lane_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (PE_OUT_BITS)
            ) u_lane_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (w_pe_out_valid[i]),
                .push_data (w_pe_out[i]),
                .pop       (w_lane_pop[i]),
                .pop_data  (w_lane_data[i]),
                .empty     (w_lane_empty[i])
            );
        end
    endgenerate

    lane_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NUM_PE)
    ) u_mask_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_up_hs),
        .push_data (bus.in_lane_en),
        .pop       (w_dn_hs),
        .pop_data  (w_mask_head),
        .empty     (w_mask_empty)
    );

    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_out_data[i*PE_OUT_BITS +: PE_OUT_BITS] = w_out_en[i] ? w_lane_data[i] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= '0;
            r_inflight <= '0;
        end else begin
            if (w_up_hs) r_done <= '0;
            else         r_done <= r_done | (w_pe_in_valid & w_pe_in_ready);
            case ({w_up_hs, w_dn_hs})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule
`default_nettype wire
